// File: rtl/ice_sl_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ice_sl_arbiter
// Brief   : ICE slave-bus arbiter: fixed/round-robin grant with a one-cycle gap
//           between grants; optional hold-timeout watchdog (ICE_ARB_TIMEOUT_EN).
// Revision: 1.0
// ============================================================================
module ice_sl_arbiter #(
  parameter int NUM_DEV   = 7,
  parameter int IDX_W     = 3,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rr_mode,
  input  logic [NUM_DEV-1:0]   sl_arb_request,
  output logic [NUM_DEV-1:0]   sl_arb_grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 timeout_evt,
  output logic [IDX_W-1:0]     timeout_idx
);

  localparam int SPAN = 2**IDX_W;
  localparam int CW   = IDX_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_granted;
  logic [NUM_DEV-1:0] eligible;
  logic [SPAN-1:0]    req_pad;
  logic [SPAN-1:0]    elig_pad;
  logic               any_elig;
  logic [IDX_W-1:0]   winner;
  logic [CW-1:0]      cand;
  logic               holder_req;
  logic               revoke;

`ifdef ICE_ARB_TIMEOUT_EN
  logic [NUM_DEV-1:0]   lockout;
  logic [TIMEOUT_W-1:0] hold_cnt;

  assign eligible = sl_arb_request & ~lockout;
  assign revoke   = (state == GRANT) && holder_req && (timeout_limit != '0) &&
                    (hold_cnt == timeout_limit - TIMEOUT_W'(1));

  // A revoked device stays locked out until its request is seen low.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt    <= '0;
      lockout     <= '0;
      timeout_evt <= 1'b0;
      timeout_idx <= '0;
    end else begin
      timeout_evt <= revoke;
      lockout     <= lockout & sl_arb_request;
      if (revoke) begin
        timeout_idx          <= grant_idx;
        lockout[grant_idx]   <= 1'b1;
      end
      if (state == IDLE && any_elig)
        hold_cnt <= '0;
      else if (state == GRANT && hold_cnt != '1)
        hold_cnt <= hold_cnt + TIMEOUT_W'(1);
    end
  end
`else
  logic unused_timeout_limit;

  assign eligible             = sl_arb_request;
  assign revoke               = 1'b0;
  assign timeout_evt          = 1'b0;
  assign timeout_idx          = '0;
  assign unused_timeout_limit = ^timeout_limit;
`endif

  always_comb begin
    req_pad                 = '0;
    req_pad[NUM_DEV-1:0]    = sl_arb_request;
    elig_pad                = '0;
    elig_pad[NUM_DEV-1:0]   = eligible;
  end

  assign holder_req = req_pad[grant_idx];

  // Search order starts at 0 (fixed) or just after the last grant (round-robin).
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    cand     = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (rr_mode) begin
        cand = {1'b0, last_granted} + CW'(k + 1);
        if (cand >= CW'(NUM_DEV))
          cand = cand - CW'(NUM_DEV);
      end else begin
        cand = CW'(k);
      end
      if (!any_elig && elig_pad[cand[IDX_W-1:0]]) begin
        any_elig = 1'b1;
        winner   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sl_arb_grant <= '0;
      grant_idx    <= '0;
      grant_valid  <= 1'b0;
      last_granted <= IDX_W'(NUM_DEV - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            sl_arb_grant <= NUM_DEV'(1) << winner;
            grant_idx    <= winner;
            grant_valid  <= 1'b1;
            last_granted <= winner;
            state        <= GRANT;
          end
        end
        GRANT: begin
          // grant_idx is left untouched so the bus mux select never glitches.
          if (!holder_req || revoke) begin
            sl_arb_grant <= '0;
            grant_valid  <= 1'b0;
            state        <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ice_sl_arbiter.sv
`default_nettype none
// Bench for ice_sl_arbiter: per-cycle comparison against a spec-level model
// plus directed scenarios with hand-computed grant orders and latencies.
module tb_ice_sl_arbiter;

  localparam int NUM = 7;
  localparam int IW  = 3;
  localparam int TW  = 16;
`ifdef ICE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            rr_mode;
  logic [NUM-1:0]  sl_arb_request;
  logic [NUM-1:0]  sl_arb_grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_valid;
  logic [TW-1:0]   timeout_limit;
  logic            timeout_evt;
  logic [IW-1:0]   timeout_idx;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ice_sl_arbiter #(.NUM_DEV(NUM), .IDX_W(IW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .rr_mode(rr_mode),
    .sl_arb_request(sl_arb_request), .sl_arb_grant(sl_arb_grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid),
    .timeout_limit(timeout_limit), .timeout_evt(timeout_evt),
    .timeout_idx(timeout_idx)
  );

  always #5 clk = ~clk;

  // Model: owner = device holding the bus (-1 none); gap = in the dead cycle.
  typedef struct packed {
    int owner; bit gap; int idx; int last; int held; bit evt; int tidx;
    bit [NUM-1:0] lock;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t s, logic rst, logic rr,
                                        logic [NUM-1:0] req, logic [TW-1:0] lim);
    model_t n = s;
    int lock_set = -1;
    n.evt = 1'b0;
    if (rst) begin
      n.owner = -1; n.gap = 1'b0; n.idx = 0; n.last = NUM - 1;
      n.held = 0; n.tidx = 0; n.lock = '0;
      return n;
    end
    if (s.owner >= 0) begin
      if (!req[s.owner]) begin
        n.owner = -1; n.gap = 1'b1;
      end else if (TO_EN && lim != 0 && s.held == int'(lim) - 1) begin
        n.evt = 1'b1; n.tidx = s.owner; lock_set = s.owner;
        n.owner = -1; n.gap = 1'b1;
      end else if (s.held < (1 << TW) - 1) begin
        n.held = s.held + 1;
      end
    end else if (s.gap) begin
      n.gap = 1'b0;
    end else begin
      for (int k = 0; k < NUM; k++) begin
        int d = rr ? (s.last + 1 + k) % NUM : k;
        if (req[d] && !s.lock[d]) begin
          n.owner = d; n.idx = d; n.last = d; n.held = 0;
          break;
        end
      end
    end
    n.lock = s.lock & req;
    if (lock_set >= 0) n.lock[lock_set] = 1'b1;
    return n;
  endfunction

  function automatic logic [NUM-1:0] exp_vec(int owner);
    return (owner >= 0) ? (NUM'(1) << owner) : '0;
  endfunction

  always @(posedge clk) m <= model_step(m, reset, rr_mode, sl_arb_request, timeout_limit);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant_vec",   32'(sl_arb_grant), 32'(exp_vec(m.owner)));
      check("grant_valid", 32'(grant_valid),  32'(m.owner >= 0));
      check("grant_idx",   32'(grant_idx),    32'(m.idx));
      check("timeout_evt", 32'(timeout_evt),  32'(m.evt));
      check("timeout_idx", 32'(timeout_idx),  32'(m.tidx));
      if (grant_valid)
        check("idx_vs_onehot", 32'(sl_arb_grant), 32'(NUM'(1) << grant_idx));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    sl_arb_request = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for the next grant to start (bounded), then check who got it.
  task automatic wait_grant(input int d, input string nm);
    int n = 0;
    while (grant_valid && n < 40) begin @(negedge clk); n++; end
    do begin @(negedge clk); n++; end while (!grant_valid && n < 40);
    check({nm, "_granted"}, 32'(grant_valid), 32'd1);
    check(nm, 32'(grant_idx), 32'(d));
  endtask

  int exp1[3] = '{1, 2, 4};
  int exp2[8] = '{0, 1, 2, 3, 4, 5, 6, 0};

  initial begin
    reset = 1'b1; rr_mode = 1'b0; sl_arb_request = '0; timeout_limit = '0;
    step(2);
    chk_en = 1'b1;
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_grant", 32'(sl_arb_grant), 32'd0);

    // 1: fixed priority, 0b0010110 together
    reset = 1'b0;
    sl_arb_request = 7'b0010110;
    for (int k = 0; k < 3; k++) begin
      wait_grant(exp1[k], "fixed_order");
      step(3);
      sl_arb_request[exp1[k]] = 1'b0;
    end
    step(4);
    check("fixed_idle", 32'(grant_valid), 32'd0);

    // 2: round-robin, all requesting, each holds 4 cycles then re-raises
    do_reset();
    rr_mode = 1'b1;
    sl_arb_request = '1;
    for (int k = 0; k < 8; k++) begin
      wait_grant(exp2[k], "rr_order");
      step(3);
      sl_arb_request[exp2[k]] = 1'b0;
      step(2);
      sl_arb_request[exp2[k]] = 1'b1;
    end

    // 3: latency and gap
    do_reset();
    rr_mode = 1'b0;
    step(8);
    sl_arb_request[5] = 1'b1;
    step(1);
    check("lat_grant_valid", 32'(grant_valid), 32'd1);
    check("lat_grant_idx",   32'(grant_idx),   32'd5);
    step(3);
    sl_arb_request[3] = 1'b1;
    step(6);
    sl_arb_request[5] = 1'b0;
    step(1);
    check("lat_drop", 32'(grant_valid), 32'd0);
    step(1);
    check("lat_gap",  32'(grant_valid), 32'd0);
    step(1);
    check("lat_next_valid", 32'(grant_valid), 32'd1);
    check("lat_next_idx",   32'(grant_idx),   32'd3);

    // 4: mode switch during a grant
    do_reset();
    rr_mode = 1'b0;
    sl_arb_request = 7'b0000100;
    wait_grant(2, "mode_first");
    step(1);
    rr_mode = 1'b1;
    sl_arb_request = 7'b0100111;
    step(3);
    check("mode_hold", 32'(grant_idx), 32'd2);
    sl_arb_request[2] = 1'b0;
    wait_grant(5, "mode_rr_next");

    // 5: hold timeout (ignored when the watchdog is not built)
    do_reset();
    rr_mode = 1'b0;
    timeout_limit = 16'd8;
    sl_arb_request[4] = 1'b1;
    wait_grant(4, "to_first");
    begin
      int cnt = 1;
      while (grant_valid && cnt < 20) begin
        @(negedge clk);
        if (grant_valid) cnt++;
      end
`ifdef ICE_ARB_TIMEOUT_EN
      check("to_hold_cycles", 32'(cnt), 32'd8);
      check("to_evt",  32'(timeout_evt), 32'd1);
      check("to_idx",  32'(timeout_idx), 32'd4);
      step(1);
      check("to_evt_pulse", 32'(timeout_evt), 32'd0);
      step(6);
      check("to_locked", 32'(grant_valid), 32'd0);
      sl_arb_request[4] = 1'b0;
      step(1);
      sl_arb_request[4] = 1'b1;
      wait_grant(4, "to_regrant");
      check("to_idx_held", 32'(timeout_idx), 32'd4);
`else
      check("to_disabled_hold", 32'(cnt), 32'd20);
      check("to_evt_tied", 32'(timeout_evt), 32'd0);
`endif
    end
    timeout_limit = '0;

    // 6: reset mid-grant
    do_reset();
    rr_mode = 1'b1;
    sl_arb_request = 7'b1000000;
    wait_grant(6, "rst_pre6");
    reset = 1'b1;
    sl_arb_request = '1;
    step(1);
    check("rst_mid_grant", 32'(sl_arb_grant), 32'd0);
    check("rst_mid_valid", 32'(grant_valid),  32'd0);
    check("rst_mid_idx",   32'(grant_idx),    32'd0);
    reset = 1'b0;
    wait_grant(0, "rst_first0");
    do_reset();
    rr_mode = 1'b1;
    sl_arb_request = 7'b0001000;
    wait_grant(3, "rst_pre3");
    reset = 1'b1;
    sl_arb_request = '1;
    step(1);
    reset = 1'b0;
    wait_grant(0, "rst_rr_ptr");

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
